// File: rtl/temp_pkg.sv
// Shared types and constants for the temperature conversion / averaging datapath.
// Raw codes are unsigned 16-bit sensor words; converted values are signed centi-degrees C.
package temp_pkg;

  typedef logic signed [15:0] centi_t;

  localparam logic [15:0] TEMP_MUL = 16'd17572;
  localparam centi_t      TEMP_OFS = 16'sd4685;

  localparam logic [15:0] FAULT_CODE_ZERO = 16'h0000;
  localparam logic [15:0] FAULT_CODE_ONES = 16'hFFFF;

  localparam centi_t MIN_RESET = 16'sh7FFF;
  localparam centi_t MAX_RESET = 16'sh8000;

  // Stuck-low and stuck-high bus words are what a dead sensor returns.
  function automatic logic is_fault(input logic [15:0] code);
    return (code == FAULT_CODE_ZERO) || (code == FAULT_CODE_ONES);
  endfunction

endpackage

// File: rtl/temp_avg_win.sv
// Power-of-two moving average over the converted samples: circular buffer,
// running sum, fill counter and a registered average output.
module temp_avg_win
  import temp_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  input  centi_t in_data,
  output logic   avg_valid,
  output centi_t avg_c
);

  localparam int WIN = 1 << AVG_LOG2;
  localparam int PW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SW  = 16 + AVG_LOG2;
  localparam int FW  = AVG_LOG2 + 1;

  localparam logic [PW-1:0] WPTR_LAST = PW'(WIN - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(WIN);

  centi_t                 win_buf_r [WIN];
  logic [PW-1:0]          wptr_r;
  logic [FW-1:0]          fill_r;
  logic signed [SW-1:0]   sum_r;
  logic                   sum_valid_r;

  logic signed [SW-1:0]   sum_next_s;
  logic [FW-1:0]          fill_next_s;
  logic [PW-1:0]          wptr_next_s;

  // Next running sum, fill level and write pointer for an accepted sample.
  always_comb begin
    sum_next_s  = sum_r + SW'(in_data) - SW'(win_buf_r[wptr_r]);
    fill_next_s = fill_r;
    wptr_next_s = wptr_r + PW'(1'b1);
    if (fill_r != FILL_FULL) begin
      fill_next_s = fill_r + FW'(1'b1);
    end else begin
      fill_next_s = fill_r;
    end
    if (wptr_r == WPTR_LAST) begin
      wptr_next_s = '0;
    end else begin
      wptr_next_s = wptr_r + PW'(1'b1);
    end
  end

  // Window state: buffer slot replaced, sum adjusted, pointer advanced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN; i++) begin
        win_buf_r[i] <= '0;
      end
      wptr_r      <= '0;
      fill_r      <= '0;
      sum_r       <= '0;
      sum_valid_r <= 1'b0;
    end else begin
      sum_valid_r <= in_valid && (fill_next_s == FILL_FULL);
      if (in_valid) begin
        win_buf_r[wptr_r] <= in_data;
        sum_r             <= sum_next_s;
        wptr_r            <= wptr_next_s;
        fill_r            <= fill_next_s;
      end
    end
  end

  // Average output; the arithmetic shift floors toward minus infinity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_valid <= 1'b0;
      avg_c     <= '0;
    end else begin
      avg_valid <= sum_valid_r;
      if (sum_valid_r) begin
        avg_c <= centi_t'(sum_r >>> AVG_LOG2);
      end
    end
  end

endmodule

// File: rtl/temp_conv_avg.sv
// Raw sensor code to centi-degrees C conversion with fault filtering,
// min/max tracking, windowed average and an over-temperature alarm.
module temp_conv_avg
  import temp_pkg::*;
#(
  parameter int     AVG_LOG2 = 2,
  parameter centi_t ALARM_HI = 16'sd4000,
  parameter centi_t ALARM_LO = 16'sd3500,
  parameter int     FAULT_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               raw_valid,
  input  logic [15:0]        raw_data,
  input  logic               minmax_clr,
  output logic               temp_valid,
  output centi_t             temp_c,
  output logic               avg_valid,
  output centi_t             avg_c,
  output centi_t             temp_min,
  output centi_t             temp_max,
  output logic               alarm,
  output logic [FAULT_W-1:0] fault_cnt
);

  logic          fault_s;
  logic          accept_s;
  logic [15:0]   code_s;
  centi_t        temp_s;
  logic          reload_s;

  logic          s1_valid_r;
  logic [15:0]   prod_hi_r;
  logic          first_r;
  logic          clr_pend_r;

  // Cycle-0 classification and the status-bit mask.
  always_comb begin
    fault_s  = raw_valid && is_fault(raw_data);
    accept_s = raw_valid && !is_fault(raw_data);
    code_s   = {raw_data[15:2], 2'b00};
    temp_s   = centi_t'(prod_hi_r) - TEMP_OFS;
    reload_s = first_r || clr_pend_r || minmax_clr;
  end

  // S1: only the integer part of the fixed-point product is ever consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      prod_hi_r  <= '0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        prod_hi_r <= 16'((32'(code_s) * 32'(TEMP_MUL)) >> 5'd16);
      end
    end
  end

  // S2: converted sample and its valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_valid <= 1'b0;
      temp_c     <= '0;
    end else begin
      temp_valid <= s1_valid_r;
      if (s1_valid_r) begin
        temp_c <= temp_s;
      end
    end
  end

  // Min/max trackers; a pending clear or the first sample reloads both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_min   <= MIN_RESET;
      temp_max   <= MAX_RESET;
      first_r    <= 1'b1;
      clr_pend_r <= 1'b0;
    end else begin
      if (s1_valid_r) begin
        first_r    <= 1'b0;
        clr_pend_r <= 1'b0;
        if (reload_s) begin
          temp_min <= temp_s;
          temp_max <= temp_s;
        end else begin
          if (temp_s < temp_min) begin
            temp_min <= temp_s;
          end
          if (temp_s > temp_max) begin
            temp_max <= temp_s;
          end
        end
      end else if (minmax_clr) begin
        clr_pend_r <= 1'b1;
      end
    end
  end

  // Saturating count of rejected samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_cnt <= '0;
    end else if (fault_s && (fault_cnt != {FAULT_W{1'b1}})) begin
      fault_cnt <= fault_cnt + {{(FAULT_W-1){1'b0}}, 1'b1};
    end
  end

  temp_avg_win #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (temp_valid),
    .in_data   (temp_c),
    .avg_valid (avg_valid),
    .avg_c     (avg_c)
  );

  // Alarm with hysteresis, re-evaluated on each new average.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm <= 1'b0;
    end else if (avg_valid) begin
      if (avg_c >= ALARM_HI) begin
        alarm <= 1'b1;
      end else if (avg_c < ALARM_LO) begin
        alarm <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_temp_conv_avg.sv
// Scoreboard bench for temp_conv_avg: a plain-arithmetic reference model queues
// expected conversions/averages at issue time; a monitor checks them on output.
module tb_temp_conv_avg;

  localparam int AVG_LOG2 = 2;
  localparam int WIN      = 4;
  localparam int FAULT_W  = 8;
  localparam int HI       = 4000;
  localparam int LO       = 3500;

  logic               clk;
  logic               rst_n;
  logic               raw_valid;
  logic [15:0]        raw_data;
  logic               minmax_clr;
  logic               temp_valid;
  logic [15:0]        temp_c;
  logic               avg_valid;
  logic [15:0]        avg_c;
  logic [15:0]        temp_min;
  logic [15:0]        temp_max;
  logic               alarm;
  logic [FAULT_W-1:0] fault_cnt;

  temp_conv_avg #(
    .AVG_LOG2 (AVG_LOG2),
    .ALARM_HI (16'sd4000),
    .ALARM_LO (16'sd3500),
    .FAULT_W  (FAULT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_valid  (raw_valid),
    .raw_data   (raw_data),
    .minmax_clr (minmax_clr),
    .temp_valid (temp_valid),
    .temp_c     (temp_c),
    .avg_valid  (avg_valid),
    .avg_c      (avg_c),
    .temp_min   (temp_min),
    .temp_max   (temp_max),
    .alarm      (alarm),
    .fault_cnt  (fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int t; int mn; int mx; int cyc; } temp_exp_t;
  typedef struct { int a; bit al; int cyc; } avg_exp_t;

  temp_exp_t tq[$];
  avg_exp_t  aq[$];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int win_q[$];
  int nsamp;
  bit mm_first;
  bit mm_clr;
  int mdl_min;
  int mdl_max;
  bit mdl_alarm;
  int mdl_fault;

  bit alarm_pend = 1'b0;
  bit alarm_exp  = 1'b0;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic int conv(logic [15:0] d);
    longint p;
    p = longint'(d & 16'hFFFC) * 64'sd17572;
    return int'(p / 64'sd65536) - 4685;
  endfunction

  function automatic int floor_div(int s, int w);
    int r;
    r = ((s % w) + w) % w;
    return (s - r) / w;
  endfunction

  task automatic model_reset();
    tq.delete();
    aq.delete();
    win_q.delete();
    nsamp     = 0;
    mm_first  = 1'b1;
    mm_clr    = 1'b0;
    mdl_min   = 32767;
    mdl_max   = -32768;
    mdl_alarm = 1'b0;
    mdl_fault = 0;
  endtask

  task automatic model_sample(logic [15:0] d);
    temp_exp_t te;
    avg_exp_t  ae;
    int t;
    int s;
    if (d == 16'h0000 || d == 16'hFFFF) begin
      if (mdl_fault < 255) mdl_fault++;
    end else begin
      t = conv(d);
      if (mm_first || mm_clr) begin
        mdl_min = t;
        mdl_max = t;
      end else begin
        if (t < mdl_min) mdl_min = t;
        if (t > mdl_max) mdl_max = t;
      end
      mm_first = 1'b0;
      mm_clr   = 1'b0;
      te = '{t: t, mn: mdl_min, mx: mdl_max, cyc: cyc};
      tq.push_back(te);
      win_q.push_back(t);
      if (win_q.size() > WIN) void'(win_q.pop_front());
      nsamp++;
      if (nsamp >= WIN) begin
        s = 0;
        foreach (win_q[i]) s += win_q[i];
        ae.a = floor_div(s, WIN);
        if (ae.a >= HI) mdl_alarm = 1'b1;
        else if (ae.a < LO) mdl_alarm = 1'b0;
        ae.al  = mdl_alarm;
        ae.cyc = cyc;
        aq.push_back(ae);
      end
    end
  endtask

  task automatic send(logic [15:0] d);
    @(negedge clk);
    raw_valid = 1'b1;
    raw_data  = d;
    model_sample(d);
  endtask

  task automatic idle(int n);
    @(negedge clk);
    raw_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int k;
    k = 0;
    @(negedge clk);
    raw_valid = 1'b0;
    while ((tq.size() != 0 || aq.size() != 0 || alarm_pend) && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (tq.size() != 0 || aq.size() != 0 || alarm_pend) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d temp / %0d avg results outstanding, expected 0", tq.size(), aq.size());
      tq.delete();
      aq.delete();
    end
    @(negedge clk);
  endtask

  task automatic clr_minmax();
    @(negedge clk);
    raw_valid  = 1'b0;
    minmax_clr = 1'b1;
    mm_clr     = 1'b1;
    @(negedge clk);
    minmax_clr = 1'b0;
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_temp_valid"}, int'(temp_valid), 0);
    chk({tag, "_avg_valid"}, int'(avg_valid), 0);
    chk({tag, "_temp_c"}, int'($signed(temp_c)), 0);
    chk({tag, "_avg_c"}, int'($signed(avg_c)), 0);
    chk({tag, "_min"}, int'($signed(temp_min)), 32767);
    chk({tag, "_max"}, int'($signed(temp_max)), -32768);
    chk({tag, "_alarm"}, int'(alarm), 0);
    chk({tag, "_fault"}, int'(fault_cnt), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    raw_valid  = 1'b0;
    minmax_clr = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops expected results whenever the DUT presents one.
  always @(negedge clk) begin
    if (!rst_n) begin
      alarm_pend = 1'b0;
    end else begin
      if (alarm_pend) begin
        chk("alarm", int'(alarm), int'(alarm_exp));
        alarm_pend = 1'b0;
      end
      if (temp_valid) begin
        if (tq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_temp_valid: got temp_c=%0d, expected no pulse", $signed(temp_c));
        end else begin
          temp_exp_t e;
          e = tq.pop_front();
          chk("temp_c", int'($signed(temp_c)), e.t);
          chk("temp_min", int'($signed(temp_min)), e.mn);
          chk("temp_max", int'($signed(temp_max)), e.mx);
          chk("temp_latency", cyc, e.cyc + 2);
        end
      end
      if (avg_valid) begin
        if (aq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_avg_valid: got avg_c=%0d, expected no pulse", $signed(avg_c));
        end else begin
          avg_exp_t e;
          e = aq.pop_front();
          chk("avg_c", int'($signed(avg_c)), e.a);
          chk("avg_latency", cyc, e.cyc + 4);
          alarm_pend = 1'b1;
          alarm_exp  = e.al;
        end
      end
    end
  end

  initial begin
    logic [15:0] d;
    rst_n      = 1'b0;
    raw_valid  = 1'b0;
    raw_data   = 16'h0000;
    minmax_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("init");
    rst_n = 1'b1;

    // basic conversions and status-bit masking
    send(16'h6000);
    idle(6);
    send(16'h0004);
    send(16'h6003);
    drain();

    // first average after a full window
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(16'h6000);
      idle(2);
    end
    drain();
    chk("avg_1904", int'($signed(avg_c)), 1904);

    // alarm set, hold, clear
    do_reset();
    for (int i = 0; i < 4; i++) send(16'h8000);
    drain();
    chk("alarm_set", int'(alarm), 1);
    send(16'h6000);
    drain();
    chk("avg_3551", int'($signed(avg_c)), 3551);
    chk("alarm_hold", int'(alarm), 1);
    send(16'h6000);
    drain();
    chk("avg_3002", int'($signed(avg_c)), 3002);
    chk("alarm_clear", int'(alarm), 0);

    // faults and saturation
    send(16'h0000);
    send(16'hFFFF);
    drain();
    chk("fault_two", int'(fault_cnt), 2);
    for (int i = 0; i < 298; i++) send(((i % 2) == 0) ? 16'h0000 : 16'hFFFF);
    drain();
    chk("fault_sat", int'(fault_cnt), 255);

    // min/max and clear
    do_reset();
    send(16'h6000);
    send(16'h8000);
    send(16'h0004);
    drain();
    chk("min_track", int'($signed(temp_min)), -4684);
    chk("max_track", int'($signed(temp_max)), 4101);
    clr_minmax();
    send(16'h6000);
    drain();
    chk("min_clr", int'($signed(temp_min)), 1904);
    chk("max_clr", int'($signed(temp_max)), 1904);

    // reset with samples in flight, then a fresh back-to-back window
    do_reset();
    send(16'h6000);
    send(16'h6000);
    do_reset();
    for (int i = 0; i < 4; i++) send(16'h6000);
    drain();
    chk("avg_after_rst", int'($signed(avg_c)), 1904);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      int sel;
      int gap;
      sel = $urandom_range(0, 9);
      if (sel == 0) d = 16'h0000;
      else if (sel == 1) d = 16'hFFFF;
      else if (sel < 6) d = 16'h7000 + 16'($urandom_range(0, 16'h2400));
      else d = 16'($urandom);
      send(d);
      gap = $urandom_range(0, 3);
      if (gap > 1) idle(gap - 2);
      if ((i % 60) == 59) begin
        drain();
        clr_minmax();
      end
    end
    drain();
    chk("fault_final", int'(fault_cnt), mdl_fault);
    chk("alarm_final", int'(alarm), int'(mdl_alarm));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
